ahb_interconnect: RTL

AHB_INTERCONNECT -- requirements
Module: ahb_interconnect

---
 rtl/ahb_pkg.sv | 18 +
 rtl/ahb_default_slave.sv | 57 +++++
 rtl/ahb_interconnect.sv | 88 ++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the default-slave state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR response for active transfers to unmapped
// regions, plus a saturating count of those errors.
//
// state   | meaning
// DS_IDLE | no error response in progress, zero-wait OKAY
// DS_ERR1 | first ERROR cycle, ready low
// DS_ERR2 | second ERROR cycle, ready high, next address phase accepted
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       err_start,
    input  logic       err_clr,
    output logic       ready,
    output logic       resp,
    output logic [7:0] err_count
);

    ds_state_t state;
    ds_state_t state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DS_IDLE: if (err_start) state_next = DS_ERR1;
            DS_ERR1: state_next = DS_ERR2;
            DS_ERR2: state_next = err_start ? DS_ERR1 : DS_IDLE;
            default: state_next = DS_IDLE;
        endcase
    end

    // Outputs kept apart from the next-state logic: err_start is derived from
    // ready at the top level, so mixing them would form a false loop.
    assign ready = (state != DS_ERR1);
    assign resp  = (state == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;

    // Every ERR1 is followed by ERR2, so counting in ERR1 counts ERR2 entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (err_clr) begin
            err_count <= 8'd0;
        end else if (state == DS_ERR1 && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: rtl/ahb_interconnect.sv
// AHB-lite single-master interconnect: region decode, data-phase mux and a
// default slave for unmapped regions.
module ahb_interconnect
    import ahb_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NUM_SLAVES  = 4,
    parameter int REGION_BITS = 4
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic [WIDTH-1:0]            HADDR,
    input  logic [1:0]                  HTRANS,
    output logic                        HREADY,
    output logic                        HRESP,
    output logic [WIDTH-1:0]            HRDATA,
    output logic [NUM_SLAVES-1:0]       HSEL,
    input  logic [NUM_SLAVES*WIDTH-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]       HRESP_S,
    input  logic [NUM_SLAVES-1:0]       HREADYOUT_S,
    input  logic                        ERR_CLR,
    output logic [7:0]                  ERR_COUNT
);

    logic [REGION_BITS-1:0] region;
    logic                   addr_mapped;
    logic                   err_start;
    logic                   ds_ready;
    logic                   ds_resp;
    logic                   sel_active;
    logic                   sel_mapped;
    logic [REGION_BITS-1:0] sel_idx;
    logic                   addr_unused;

    assign region      = HADDR[WIDTH-1 -: REGION_BITS];
    assign addr_mapped = int'(region) < NUM_SLAVES;
    // Only the region bits and HTRANS[1] matter to the interconnect.
    assign addr_unused = ^{HADDR[WIDTH-REGION_BITS-1:0], HTRANS[0]};

    always_comb begin
        HSEL = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            HSEL[i] = (int'(region) == i);
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_active <= 1'b0;
            sel_mapped <= 1'b0;
            sel_idx    <= '0;
        end else if (HREADY) begin
            sel_active <= HTRANS[1];
            sel_mapped <= addr_mapped;
            sel_idx    <= region;
        end
    end

    assign err_start = HREADY && HTRANS[1] && !addr_mapped;

    ahb_default_slave u_default_slave (
        .clk       (HCLK),
        .rst       (HRESET),
        .err_start (err_start),
        .err_clr   (ERR_CLR),
        .ready     (ds_ready),
        .resp      (ds_resp),
        .err_count (ERR_COUNT)
    );

    // An inactive data phase leaves the default slave idle, which already
    // yields the zero-wait OKAY response.
    always_comb begin
        HRDATA = '0;
        HRESP  = ds_resp;
        HREADY = ds_ready;
        if (sel_active && sel_mapped) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (int'(sel_idx) == i) begin
                    HRDATA = HRDATA_S[i*WIDTH +: WIDTH];
                    HRESP  = HRESP_S[i];
                    HREADY = HREADYOUT_S[i];
                end
            end
        end
    end

endmodule
